// File: rtl/btn_conditioner.sv
// btn_conditioner: five-channel button conditioner. Each raw button passes
// through a two-flop synchronizer and then its own debounce FSM. The block
// outputs a registered debounced level per channel, a one-cycle press strobe
// per channel, and a flag that is set when two or more player buttons are
// held at the same time.
//
// Build option: define BTN_PULSE_EN to build the press-strobe registers.
// Without it, btn_pulse is tied to zero.
module btn_conditioner #(
    parameter int DB_CYCLES = 16000,
    parameter int CNT_W     = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [4:0] btn_raw,
    output logic [4:0] btn_db,
    output logic [4:0] btn_pulse,
    output logic       multi
);

    typedef enum logic [1:0] {
        ST_LOW     = 2'd0,
        ST_WAIT_HI = 2'd1,
        ST_HIGH    = 2'd2,
        ST_WAIT_LO = 2'd3
    } db_state_t;

    // The count is compared against its final value before it is
    // incremented, so it never wraps.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    // Returns 1 when at least two of the four player levels are high.
    function automatic logic at_least_two(input logic [3:0] v);
        logic [2:0] sum;
        sum = {2'b00, v[0]} + {2'b00, v[1]} + {2'b00, v[2]} + {2'b00, v[3]};
        return (sum >= 3'd2);
    endfunction

    logic [4:0]       s1_r;
    logic [4:0]       s2_r;
    db_state_t        state_r     [5];
    db_state_t        state_nxt_s [5];
    logic [CNT_W-1:0] cnt_r       [5];
    logic [CNT_W-1:0] cnt_nxt_s   [5];
    logic [4:0]       db_r;
    logic [4:0]       db_nxt_s;
    logic             multi_r;

    // Two-flop synchronizer for the asynchronous button inputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_r <= 5'b00000;
            s2_r <= 5'b00000;
        end else begin
            s1_r <= btn_raw;
            s2_r <= s1_r;
        end
    end

    // Per-channel debounce next-state, counter and level logic.
    always_comb begin
        for (int ch = 0; ch < 5; ch++) begin
            state_nxt_s[ch] = state_r[ch];
            cnt_nxt_s[ch]   = cnt_r[ch];
            db_nxt_s[ch]    = db_r[ch];
            case (state_r[ch])
                ST_LOW: begin
                    cnt_nxt_s[ch] = CNT_ZERO;
                    db_nxt_s[ch]  = 1'b0;
                    if (s2_r[ch]) begin
                        state_nxt_s[ch] = ST_WAIT_HI;
                    end else begin
                        state_nxt_s[ch] = ST_LOW;
                    end
                end
                ST_WAIT_HI: begin
                    if (!s2_r[ch]) begin
                        state_nxt_s[ch] = ST_LOW;
                        cnt_nxt_s[ch]   = CNT_ZERO;
                    end else if (cnt_r[ch] == CNT_LAST) begin
                        state_nxt_s[ch] = ST_HIGH;
                        cnt_nxt_s[ch]   = CNT_ZERO;
                        db_nxt_s[ch]    = 1'b1;
                    end else begin
                        cnt_nxt_s[ch]   = cnt_r[ch] + CNT_ONE;
                    end
                end
                ST_HIGH: begin
                    cnt_nxt_s[ch] = CNT_ZERO;
                    db_nxt_s[ch]  = 1'b1;
                    if (!s2_r[ch]) begin
                        state_nxt_s[ch] = ST_WAIT_LO;
                    end else begin
                        state_nxt_s[ch] = ST_HIGH;
                    end
                end
                ST_WAIT_LO: begin
                    if (s2_r[ch]) begin
                        state_nxt_s[ch] = ST_HIGH;
                        cnt_nxt_s[ch]   = CNT_ZERO;
                    end else if (cnt_r[ch] == CNT_LAST) begin
                        state_nxt_s[ch] = ST_LOW;
                        cnt_nxt_s[ch]   = CNT_ZERO;
                        db_nxt_s[ch]    = 1'b0;
                    end else begin
                        cnt_nxt_s[ch]   = cnt_r[ch] + CNT_ONE;
                    end
                end
                default: begin
                    state_nxt_s[ch] = ST_LOW;
                    cnt_nxt_s[ch]   = CNT_ZERO;
                    db_nxt_s[ch]    = 1'b0;
                end
            endcase
        end
    end

    // Debounce state, counter, level and multi-press registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int ch = 0; ch < 5; ch++) begin
                state_r[ch] <= ST_LOW;
                cnt_r[ch]   <= CNT_ZERO;
            end
            db_r    <= 5'b00000;
            multi_r <= 1'b0;
        end else begin
            for (int ch = 0; ch < 5; ch++) begin
                state_r[ch] <= state_nxt_s[ch];
                cnt_r[ch]   <= cnt_nxt_s[ch];
            end
            db_r    <= db_nxt_s;
            multi_r <= at_least_two(db_r[3:0]);
        end
    end

`ifdef BTN_PULSE_EN
    logic [4:0] pulse_r;

    // Press strobe: the level only rises on the WAIT_HI -> HIGH transition,
    // so a 0 -> 1 change of the next level marks that transition.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pulse_r <= 5'b00000;
        end else begin
            pulse_r <= db_nxt_s & ~db_r;
        end
    end

    assign btn_pulse = pulse_r;
`else
    assign btn_pulse = 5'b00000;
`endif

    assign btn_db = db_r;
    assign multi  = multi_r;

endmodule

// File: tb/tb_btn_conditioner.sv
// Bench for btn_conditioner with DB_CYCLES=4. A reference model predicts
// the outputs for every clock edge and pushes them to a scoreboard queue.
// The queue is popped and compared on the falling edge. Directed checks
// cover the reset state and the latency boundaries.
module tb_btn_conditioner;

    localparam int DB = 4;

    logic       clk;
    logic       rst;
    logic [4:0] btn_raw;
    logic [4:0] btn_db;
    logic [4:0] btn_pulse;
    logic       multi;

    int n_cmp;
    int n_bad;

    typedef struct packed {
        logic [4:0] db;
        logic [4:0] pulse;
        logic       multi;
    } exp_t;

    exp_t sb[$];

    btn_conditioner #(.DB_CYCLES(DB), .CNT_W(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .btn_raw   (btn_raw),
        .btn_db    (btn_db),
        .btn_pulse (btn_pulse),
        .multi     (multi)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model. A channel flips its level once it has seen a
    // synchronized value that differs from the level for DB+1 edges in a row.
    logic [4:0] m_s1;
    logic [4:0] m_s2;
    logic [4:0] m_db;
    int         m_run [5];

    // Model update per edge, with the prediction pushed to the scoreboard.
    always @(posedge clk or negedge rst) begin
        logic [4:0] db_n;
        logic [4:0] pl_n;
        exp_t       e;
        if (!rst) begin
            m_s1 <= 5'b0;
            m_s2 <= 5'b0;
            m_db <= 5'b0;
            for (int i = 0; i < 5; i++) m_run[i] <= 0;
            sb.delete();
        end else begin
            db_n = m_db;
            pl_n = 5'b0;
            for (int i = 0; i < 5; i++) begin
                if (m_s2[i] == m_db[i]) begin
                    m_run[i] <= 0;
                end else if (m_run[i] == DB) begin
                    db_n[i] = ~m_db[i];
                    pl_n[i] = ~m_db[i];
                    m_run[i] <= 0;
                end else begin
                    m_run[i] <= m_run[i] + 1;
                end
            end
`ifndef BTN_PULSE_EN
            pl_n = 5'b0;
`endif
            e.db    = db_n;
            e.pulse = pl_n;
            e.multi = ($countones(m_db[3:0]) >= 2);
            sb.push_back(e);
            m_db <= db_n;
            m_s2 <= m_s1;
            m_s1 <= btn_raw;
        end
    end

    // Scoreboard compare, away from the active edge.
    always @(negedge clk) begin
        exp_t e;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check_val("sb_db", int'(btn_db), int'(e.db));
            check_val("sb_pulse", int'(btn_pulse), int'(e.pulse));
            check_val("sb_multi", int'(multi), int'(e.multi));
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #3;
    endtask

    int exp_pulse;

    initial begin
        n_cmp   = 0;
        n_bad   = 0;
        rst     = 1'b0;
        btn_raw = 5'b0;
        tick(3);
        check_val("reset_db", int'(btn_db), 0);
        check_val("reset_pulse", int'(btn_pulse), 0);
        check_val("reset_multi", int'(multi), 0);
        rst = 1'b1;
        tick(4);

        // Clean press on channel 0: the level rises 6 edges after the first sample.
`ifdef BTN_PULSE_EN
        exp_pulse = 1;
`else
        exp_pulse = 0;
`endif
        btn_raw[0] = 1'b1;
        tick(6);
        check_val("press_db_k5", int'(btn_db[0]), 0);
        tick(1);
        check_val("press_db_k6", int'(btn_db[0]), 1);
        check_val("press_pulse_k6", int'(btn_pulse[0]), exp_pulse);
        tick(1);
        check_val("press_pulse_k7", int'(btn_pulse[0]), 0);
        btn_raw[0] = 1'b0;
        tick(10);

        // Bounce on channel 2: high for 3 samples, low for 1, then held high.
        btn_raw[2] = 1'b1;
        tick(3);
        btn_raw[2] = 1'b0;
        tick(1);
        btn_raw[2] = 1'b1;
        tick(6);
        check_val("bounce_db_j5", int'(btn_db[2]), 0);
        tick(1);
        check_val("bounce_db_j6", int'(btn_db[2]), 1);
        btn_raw[2] = 1'b0;
        tick(10);

        // Channel 1: a release glitch of 4 samples is rejected, a held release is accepted.
        btn_raw[1] = 1'b1;
        tick(10);
        btn_raw[1] = 1'b0;
        tick(4);
        btn_raw[1] = 1'b1;
        tick(8);
        check_val("glitch_db_held", int'(btn_db[1]), 1);
        btn_raw[1] = 1'b0;
        tick(6);
        check_val("release_db_j5", int'(btn_db[1]), 1);
        tick(1);
        check_val("release_db_j6", int'(btn_db[1]), 0);
        check_val("release_pulse", int'(btn_pulse[1]), 0);
        tick(6);

        // Channels 0 and 3 pressed together: multi follows one cycle after the levels.
        btn_raw = 5'b01001;
        tick(7);
        check_val("multi_db", int'(btn_db), 5'b01001);
        check_val("multi_lag", int'(multi), 0);
        tick(1);
        check_val("multi_set", int'(multi), 1);
        btn_raw = 5'b0;
        tick(10);

        // Generate button plus channel 0: two levels high, but multi stays low.
        btn_raw = 5'b10001;
        tick(10);
        check_val("gen_db", int'(btn_db), 5'b10001);
        check_val("gen_multi", int'(multi), 0);
        btn_raw = 5'b0;
        tick(10);

        // Reset asserted while channel 0 is in WAIT_HI at count 2, with channel 3 already high.
        btn_raw[3] = 1'b1;
        tick(10);
        btn_raw[0] = 1'b1;
        tick(5);
        rst = 1'b0;
        #1;
        check_val("rst_async_db", int'(btn_db), 0);
        check_val("rst_async_multi", int'(multi), 0);
        check_val("rst_async_pulse", int'(btn_pulse), 0);
        tick(2);
        rst = 1'b1;
        tick(6);
        check_val("requal_db_m5", int'(btn_db), 0);
        tick(1);
        check_val("requal_db_m6", int'(btn_db), 5'b01001);
        check_val("requal_pulse", int'(btn_pulse), (exp_pulse != 0) ? 5'b01001 : 0);
        btn_raw = 5'b0;
        tick(12);

        // Random traffic, cross-checked against the reference model.
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                btn_raw = 5'($urandom_range(0, 31));
            end
            tick(1);
        end
        tick(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
